elastic_pipe_stage: RTL

Parametrised pipeline stage register with a valid/ready handshake, a synchronous flush, and a programmable bubble value. It replaces fixed-field inter-stage registers such as IF/ID, ID/EX, EX/MEM and MEM/WB: the stage fields are packed into one `DATA_W`-bit bus. An optional skid entry lets `in_ready` be a registered signal, so backpressure does not form a combinational path back through the pipeline. When the stage is empty, its output carries `BUBBLE_VAL`, a NOP encoding, instead of stale data.

---
 rtl/elastic_pipe_stage.sv | 138 +++++++++++++
 1 files changed

// File: rtl/elastic_pipe_stage.sv
// -----------------------------------------------------------------------------
// elastic_pipe_stage
//
// Generic inter-stage pipeline register with a valid/ready handshake. The
// stage fields (IF/ID, ID/EX, ...) are packed into one DATA_W-bit payload.
// With SKID=1 a second "skid" entry absorbs one beat of backpressure so that
// in_ready comes straight from a flop. With SKID=0 the stage holds a single
// entry and in_ready is combinational. An empty stage drives BUBBLE_VAL (a
// NOP encoding) on out_data, so downstream logic may use it unqualified.
//
// Ports:
//   clk        in   rising-edge clock
//   reset_n    in   asynchronous active-low reset
//   in_valid   in   upstream presents in_data
//   in_ready   out  stage accepts this cycle
//   in_data    in   upstream payload [DATA_W-1:0]
//   out_valid  out  out_data holds a real entry
//   out_ready  in   downstream consumes this cycle
//   out_data   out  main entry payload, BUBBLE_VAL when out_valid=0
//   flush_i    in   synchronous kill of all held entries
//   occupancy  out  number of held entries (0..2)
// -----------------------------------------------------------------------------
module elastic_pipe_stage #(
   parameter int                 DATA_W     = 32,
   parameter logic [DATA_W-1:0]  BUBBLE_VAL = {DATA_W{1'b0}},
   parameter bit                 SKID       = 1'b1
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   input  logic              flush_i,
   output logic [1:0]        occupancy
);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_q, main_d;
   logic [DATA_W-1:0] skid_q, skid_d;
   logic              vld_q, vld_d;
   logic [1:0]        occ_q, occ_d;
   logic              rdy_q, rdy_d;
   logic              accept, consume;

   // With SKID=1 the ready flag is a flop; with SKID=0 the single entry can be
   // refilled in the same cycle it is consumed, so ready looks at out_ready.
   assign in_ready  = SKID ? rdy_q : (!vld_q || out_ready);
   assign accept    = in_valid && in_ready;
   assign consume   = vld_q && out_ready;

   assign out_valid = vld_q;
   assign out_data  = main_q;
   assign occupancy = occ_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= ST_EMPTY;
         main_q  <= BUBBLE_VAL;
         skid_q  <= BUBBLE_VAL;
         vld_q   <= 1'b0;
         occ_q   <= 2'd0;
         rdy_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
         vld_q   <= vld_d;
         occ_q   <= occ_d;
         rdy_q   <= rdy_d;
      end
   end

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      unique case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = in_data;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && consume) begin
               main_d = in_data;
            end else if (accept && SKID) begin
               // Downstream stalled: park the new beat behind main.
               skid_d  = in_data;
               state_d = ST_FULL;
            end else if (consume) begin
               main_d  = BUBBLE_VAL;
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            // in_ready is low here, so only the drain path exists.
            if (consume) begin
               main_d  = skid_q;
               skid_d  = BUBBLE_VAL;
               state_d = ST_ONE;
            end
         end
         default: begin
            main_d  = BUBBLE_VAL;
            skid_d  = BUBBLE_VAL;
            state_d = ST_EMPTY;
         end
      endcase

      // Flush overrides everything, including a same-cycle accept, which is
      // deliberately dropped. A same-cycle consume still counts downstream.
      if (flush_i) begin
         state_d = ST_EMPTY;
         main_d  = BUBBLE_VAL;
         skid_d  = BUBBLE_VAL;
      end

      vld_d = (state_d != ST_EMPTY);
      rdy_d = (state_d != ST_FULL);
      unique case (state_d)
         ST_ONE:  occ_d = 2'd1;
         ST_FULL: occ_d = 2'd2;
         default: occ_d = 2'd0;
      endcase
   end

endmodule
